// File: rtl/addr_reg_bank_if.sv
// Command and burst bus between the command decoder and addr_reg_bank.
// slave = register bank side, master = decoder/consumer side.
interface addr_reg_bank_if #(
  parameter int WORD_SIZE = 32,
  parameter int CH_W      = 2
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [CH_W-1:0]      cmd_ch;
  logic [WORD_SIZE-1:0] cmd_data;
  logic [CH_W-1:0]      rd_ch;
  logic [WORD_SIZE-1:0] data_out;
  logic [WORD_SIZE-1:0] bst_addr;
  logic                 bst_valid;
  logic                 bst_ready;
  logic                 busy;
  logic                 burst_done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_data, rd_ch, bst_ready,
    output cmd_ready, data_out, bst_addr, bst_valid, busy, burst_done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_data, rd_ch, bst_ready,
    input  cmd_ready, data_out, bst_addr, bst_valid, busy, burst_done
  );
endinterface

// File: rtl/addr_reg_bank.sv
// Multi-channel address pointer bank with base/limit/stride wrap and handshaked bursts.
// Optional ADDR_WRAP_FLAG_EN adds sticky per-channel wrap_flags output.
//
// state   | meaning
// S_IDLE  | accepting commands
// S_BURST | presenting ptr[burst channel] on bst_addr until count beats accepted
module addr_reg_bank #(
  parameter int WORD_SIZE = 32,
  parameter int LOW_BITS  = 20,
  parameter int CHANNELS  = 4,
  parameter int CH_W      = 2,
  parameter int CNT_W     = 8
) (
  input  logic                clock,
  input  logic                reset,
  addr_reg_bank_if.slave      bus
`ifdef ADDR_WRAP_FLAG_EN
  ,
  output logic [CHANNELS-1:0] wrap_flags
`endif
);
  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [2:0] OP_LOAD       = 3'd1;
  localparam logic [2:0] OP_LOAD_LOW   = 3'd2;
  localparam logic [2:0] OP_SET_BASE   = 3'd3;
  localparam logic [2:0] OP_SET_LIMIT  = 3'd4;
  localparam logic [2:0] OP_SET_STRIDE = 3'd5;
  localparam logic [2:0] OP_STEP       = 3'd6;
  localparam logic [2:0] OP_BURST      = 3'd7;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] ptr_q    [CHANNELS];
  logic [WORD_SIZE-1:0] ptr_d    [CHANNELS];
  logic [WORD_SIZE-1:0] base_q   [CHANNELS];
  logic [WORD_SIZE-1:0] base_d   [CHANNELS];
  logic [WORD_SIZE-1:0] limit_q  [CHANNELS];
  logic [WORD_SIZE-1:0] limit_d  [CHANNELS];
  logic [WORD_SIZE-1:0] stride_q [CHANNELS];
  logic [WORD_SIZE-1:0] stride_d [CHANNELS];
  logic [CH_W-1:0]      bst_ch_q, bst_ch_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic                 done_q, done_d;
  logic                 accept, beat;
  logic [CNT_W-1:0]     cnt;
`ifdef ADDR_WRAP_FLAG_EN
  logic [CHANNELS-1:0]  wrap_q, wrap_d;
`endif

  // Carry out of the wider sum counts as overflow past limit.
  function automatic logic wraps(input logic [WORD_SIZE-1:0] p, s, l);
    logic [WORD_SIZE:0] sum;
    sum   = {1'b0, p} + {1'b0, s};
    wraps = sum[WORD_SIZE] || (sum[WORD_SIZE-1:0] > l);
  endfunction

  function automatic logic [WORD_SIZE-1:0] next_ptr(input logic [WORD_SIZE-1:0] p, s, b, l);
    next_ptr = wraps(p, s, l) ? b : p + s;
  endfunction

  assign accept = bus.cmd_valid && (state_q == S_IDLE);
  assign beat   = (state_q == S_BURST) && bus.bst_ready;
  assign cnt    = bus.cmd_data[CNT_W-1:0];

  always_comb begin
    state_d  = state_q;
    bst_ch_d = bst_ch_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    ptr_d    = ptr_q;
    base_d   = base_q;
    limit_d  = limit_q;
    stride_d = stride_q;
`ifdef ADDR_WRAP_FLAG_EN
    wrap_d   = wrap_q;
`endif
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (accept && (bus.cmd_ch == CH_W'(ch))) begin
        case (bus.cmd_op)
          OP_LOAD: begin
            ptr_d[ch] = bus.cmd_data;
`ifdef ADDR_WRAP_FLAG_EN
            wrap_d[ch] = 1'b0;
`endif
          end
          OP_LOAD_LOW: begin
            ptr_d[ch] = WORD_SIZE'(bus.cmd_data[LOW_BITS-1:0]);
`ifdef ADDR_WRAP_FLAG_EN
            wrap_d[ch] = 1'b0;
`endif
          end
          OP_SET_BASE: begin
            base_d[ch] = bus.cmd_data;
            ptr_d[ch]  = bus.cmd_data;
`ifdef ADDR_WRAP_FLAG_EN
            wrap_d[ch] = 1'b0;
`endif
          end
          OP_SET_LIMIT:  limit_d[ch]  = bus.cmd_data;
          OP_SET_STRIDE: stride_d[ch] = bus.cmd_data;
          OP_STEP: begin
            ptr_d[ch] = next_ptr(ptr_q[ch], stride_q[ch], base_q[ch], limit_q[ch]);
`ifdef ADDR_WRAP_FLAG_EN
            if (wraps(ptr_q[ch], stride_q[ch], limit_q[ch])) wrap_d[ch] = 1'b1;
`endif
          end
          OP_BURST: begin
            if (cnt != '0) begin
              state_d  = S_BURST;
              bst_ch_d = CH_W'(ch);
              rem_d    = cnt;
            end
          end
          default: ;
        endcase
      end
      if (beat && (bst_ch_q == CH_W'(ch))) begin
        ptr_d[ch] = next_ptr(ptr_q[ch], stride_q[ch], base_q[ch], limit_q[ch]);
`ifdef ADDR_WRAP_FLAG_EN
        if (wraps(ptr_q[ch], stride_q[ch], limit_q[ch])) wrap_d[ch] = 1'b1;
`endif
      end
    end
    if (beat) begin
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      bst_ch_q <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        ptr_q[ch]    <= '0;
        base_q[ch]   <= '0;
        limit_q[ch]  <= '1;
        stride_q[ch] <= WORD_SIZE'(1);
      end
`ifdef ADDR_WRAP_FLAG_EN
      wrap_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bst_ch_q <= bst_ch_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      ptr_q    <= ptr_d;
      base_q   <= base_d;
      limit_q  <= limit_d;
      stride_q <= stride_d;
`ifdef ADDR_WRAP_FLAG_EN
      wrap_q   <= wrap_d;
`endif
    end
  end

  always_comb begin
    bus.data_out = '0;
    bus.bst_addr = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (bus.rd_ch == CH_W'(ch)) bus.data_out = ptr_q[ch];
      if (bst_ch_q == CH_W'(ch))  bus.bst_addr = ptr_q[ch];
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q == S_BURST);
  assign bus.bst_valid  = (state_q == S_BURST);
  assign bus.burst_done = done_q;
`ifdef ADDR_WRAP_FLAG_EN
  assign wrap_flags = wrap_q;
`endif
endmodule

// File: tb/tb_addr_reg_bank.sv
// Directed self-checking bench for addr_reg_bank; checks wrap_flags when
// built with ADDR_WRAP_FLAG_EN.
module tb_addr_reg_bank;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  addr_reg_bank_if #(.WORD_SIZE(W), .CH_W(2)) bus ();
`ifdef ADDR_WRAP_FLAG_EN
  logic [3:0] wrap_flags;
`endif

  addr_reg_bank #(.WORD_SIZE(W), .LOW_BITS(20), .CHANNELS(4), .CH_W(2), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ADDR_WRAP_FLAG_EN
    ,
    .wrap_flags (wrap_flags)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] ch, input logic [W-1:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ch    = ch;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
  endtask

  task automatic rd(input logic [1:0] ch, input string tag, input logic [W-1:0] exp);
    bus.rd_ch = ch;
    #1;
    chk(tag, bus.data_out, exp);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_ch    = 2'd0;
    bus.cmd_data  = '0;
    bus.rd_ch     = 2'd0;
    bus.bst_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // reset state
    for (int r = 0; r < 4; r++) rd(2'(r), "reset_ptr", 32'h0);
    chk("reset_ready", W'(bus.cmd_ready), 32'd1);
    chk("reset_bvalid", W'(bus.bst_valid), 32'd0);
    chk("reset_busy", W'(bus.busy), 32'd0);

    send(3'd1, 2'd1, 32'hDEADBEEF);
    rd(2'd1, "load_ch1", 32'hDEADBEEF);
    send(3'd2, 2'd0, 32'hFFFFFFFF);
    rd(2'd0, "load_low_ch0", 32'h000FFFFF);

    // stepping with wrap at limit
    send(3'd3, 2'd2, 32'h100);
    send(3'd4, 2'd2, 32'h10C);
    send(3'd5, 2'd2, 32'h4);
    rd(2'd2, "set_base_ptr", 32'h100);
    send(3'd6, 2'd2, 0); rd(2'd2, "step1", 32'h104);
    send(3'd6, 2'd2, 0); rd(2'd2, "step2", 32'h108);
    send(3'd6, 2'd2, 0); rd(2'd2, "step3_at_limit", 32'h10C);
`ifdef ADDR_WRAP_FLAG_EN
    chk("wflag_before", W'(wrap_flags), 32'h0);
`endif
    send(3'd6, 2'd2, 0); rd(2'd2, "step4_wrap", 32'h100);
`ifdef ADDR_WRAP_FLAG_EN
    chk("wflag_set", W'(wrap_flags), 32'h4);
    send(3'd1, 2'd2, 32'h55);
    chk("wflag_clr", W'(wrap_flags), 32'h0);
`endif

    // stride 0 with ptr above limit wraps to base
    send(3'd4, 2'd1, 32'h1000);
    send(3'd5, 2'd1, 32'h0);
    send(3'd6, 2'd1, 0); rd(2'd1, "stride0_wrap", 32'h0);
    // carry out wraps to base
    send(3'd1, 2'd0, 32'hFFFFFFF0);
    send(3'd5, 2'd0, 32'h20);
    send(3'd6, 2'd0, 0); rd(2'd0, "carry_wrap", 32'h0);

    // burst of 3 with consumer always ready
    send(3'd3, 2'd3, 32'h200);
    send(3'd5, 2'd3, 32'h8);
    bus.bst_ready = 1'b1;
    bus.rd_ch     = 2'd3;
    send(3'd7, 2'd3, 32'h3);
    chk("b3_addr0", bus.bst_addr, 32'h200);
    chk("b3_valid0", W'(bus.bst_valid), 32'd1);
    chk("b3_ready0", W'(bus.cmd_ready), 32'd0);
    chk("b3_dout0", bus.data_out, 32'h200);
    tick();
    chk("b3_addr1", bus.bst_addr, 32'h208);
    chk("b3_ready1", W'(bus.cmd_ready), 32'd0);
    chk("b3_dout1", bus.data_out, 32'h208);
    tick();
    chk("b3_addr2", bus.bst_addr, 32'h210);
    chk("b3_ready2", W'(bus.cmd_ready), 32'd0);
    tick();
    chk("b3_done", W'(bus.burst_done), 32'd1);
    chk("b3_valid_end", W'(bus.bst_valid), 32'd0);
    chk("b3_ready_end", W'(bus.cmd_ready), 32'd1);
    chk("b3_ptr", bus.data_out, 32'h218);
    tick();
    chk("b3_done_pulse", W'(bus.burst_done), 32'd0);

    // burst of 2 with consumer stalled for 5 cycles
    bus.bst_ready = 1'b0;
    send(3'd7, 2'd3, 32'h2);
    for (int i = 0; i < 5; i++) begin
      chk("b2_stall_addr", bus.bst_addr, 32'h218);
      chk("b2_stall_busy", W'(bus.busy), 32'd1);
      tick();
    end
    bus.bst_ready = 1'b1;
    tick();
    chk("b2_addr1", bus.bst_addr, 32'h220);
    chk("b2_done_early", W'(bus.burst_done), 32'd0);
    tick();
    chk("b2_done", W'(bus.burst_done), 32'd1);
    chk("b2_busy_end", W'(bus.busy), 32'd0);
    rd(2'd3, "b2_ptr", 32'h228);

    // count 0 (only low 8 bits count) is a no-op
    send(3'd7, 2'd3, 32'h100);
    chk("b0_busy", W'(bus.busy), 32'd0);
    chk("b0_ready", W'(bus.cmd_ready), 32'd1);
    tick();
    chk("b0_done", W'(bus.burst_done), 32'd0);
    rd(2'd3, "b0_ptr", 32'h228);

    // reset mid-burst
    send(3'd7, 2'd3, 32'h4);
    tick();
    chk("mid_addr", bus.bst_addr, 32'h230);
    reset = 1'b0;
    #1;
    chk("rst_valid", W'(bus.bst_valid), 32'd0);
    chk("rst_busy", W'(bus.busy), 32'd0);
    chk("rst_ptr3", bus.data_out, 32'h0);
    chk("rst_done", W'(bus.burst_done), 32'd0);
    tick();
    chk("rst_done_hold", W'(bus.burst_done), 32'd0);
    reset = 1'b1;
    bus.bst_ready = 1'b0;
    tick();
    chk("post_rst_done", W'(bus.burst_done), 32'd0);
    send(3'd6, 2'd3, 0); rd(2'd3, "post_rst_stride1", 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_reg_bank.md
Name: addr_reg_bank

Overview:
Multi-channel successor to the single address register. Holds CHANNELS independent address pointers, each with its own base, limit and stride. Pointers are loaded full-width or low-field-only. They advance with wrap-to-base, either on a single-step command or autonomously in a handshaked burst. It sits between the command decoder and the memory/peripheral address bus.

Parameters:
WORD_SIZE, 32, width of pointers, base, limit, stride and command data
LOW_BITS, 20, width of the low field used by LOAD_LOW (1..WORD_SIZE)
CHANNELS, 4, number of pointer channels (1..2**CH_W)
CH_W, 2, width of channel select fields
CNT_W, 8, width of burst count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  3  opcode (see Behaviour)
cmd_ch  in  CH_W  target channel
cmd_data  in  WORD_SIZE  command operand
rd_ch  in  CH_W  read channel select
data_out  out  WORD_SIZE  ptr[rd_ch], combinational read of registered pointer
bst_addr  out  WORD_SIZE  current burst address
bst_valid  out  1  burst address valid
bst_ready  in  1  consumer accepts bst_addr
busy  out  1  high in BURST state
burst_done  out  1  one-cycle pulse after last burst beat accepted

Behaviour:
- Reset (async, reset==0): ptr=0, base=0, limit=all ones, stride=1 for every channel. FSM=IDLE. bst_valid=0, burst_done=0, busy=0. cmd_ready=1 once reset deasserts.
- All register updates occur on the rising clock edge when a command is accepted (cmd_valid && cmd_ready).
- Opcodes:
  - 0 NOP: no effect.
  - 1 LOAD: ptr <= cmd_data.
  - 2 LOAD_LOW: ptr <= {zeros, cmd_data[LOW_BITS-1:0]}.
  - 3 SET_BASE: base <= cmd_data and ptr <= cmd_data.
  - 4 SET_LIMIT: limit <= cmd_data.
  - 5 SET_STRIDE: stride <= cmd_data.
  - 6 STEP: ptr advances once.
  - 7 BURST: burst count = cmd_data[CNT_W-1:0].
- Advance rule: sum = ptr + stride, computed at WORD_SIZE+1 bits.
  - If the carry is set or sum[WORD_SIZE-1:0] > limit: ptr <= base (wrap).
  - Else: ptr <= sum[WORD_SIZE-1:0].
  - stride=0 leaves ptr unchanged unless ptr > limit, which wraps to base.
- cmd_ch >= CHANNELS: command accepted and ignored.
- FSM IDLE:
  - cmd_ready=1.
  - BURST with count=0 is accepted as a no-op: no state change, no burst_done.
  - BURST with count>0 latches the channel and remaining=count, then moves to BURST.
- FSM BURST:
  - cmd_ready=0, busy=1, bst_valid=1, bst_addr=ptr[burst_ch].
  - First beat is visible the cycle after acceptance.
  - On bst_valid && bst_ready: ptr[burst_ch] advances and remaining decrements.
  - If remaining was 1: next state IDLE, burst_done=1 for exactly one cycle, bst_valid=0.
  - bst_ready low: all burst state holds and bst_addr is stable.
- data_out reflects a pointer update the cycle after the edge, including burst advances when rd_ch == burst_ch.
- Reset mid-burst: immediate abort to the reset state. No burst_done pulse.

Optional Feature:
Macro ADDR_WRAP_FLAG_EN.
- Defined: adds output port wrap_flags [CHANNELS-1:0], reset to 0.
  - Bit ch is set on any wrap of channel ch (STEP or burst beat).
  - Cleared by LOAD, LOAD_LOW or SET_BASE on that channel.
  - Set wins if both occur in the same cycle.
- Undefined: port absent; wraps are silent; all other behaviour identical.

Test Plan:
1. Reset released -> data_out=0 for every rd_ch, cmd_ready=1, bst_valid=0. LOAD ch1 0xDEADBEEF -> data_out(rd_ch=1)=0xDEADBEEF next cycle.
2. LOAD_LOW ch0 cmd_data=0xFFFFFFFF with LOW_BITS=20 -> ptr0=0x000FFFFF.
3. ch2: SET_BASE 0x100, SET_LIMIT 0x10C, SET_STRIDE 4, STEP x4 -> ptr sequence 0x104, 0x108, 0x10C, 0x100.
4. ch3: SET_BASE 0x200, SET_STRIDE 8, BURST count 3 with bst_ready=1 -> bst_addr 0x200, 0x208, 0x210 on consecutive cycles. burst_done pulses once, ptr3=0x218, cmd_ready low for exactly 3 cycles.
5. BURST count 2 with bst_ready low for 5 cycles then high -> bst_addr held stable for 5 cycles; exactly 2 beats delivered. BURST count 0 -> busy never asserts.
6. Reset asserted mid-burst after 1 beat -> bst_valid=0 and ptrs=0 immediately, no burst_done. With ADDR_WRAP_FLAG_EN, scenario 3 sets wrap_flags[2]=1 and a following LOAD ch2 clears it.
